// File: rtl/ir_fetch_buffer_if.sv
// Fetch-side valid/ready handshake plus the decoded head-of-buffer bundle.
// slave = the buffer, master = the fetch source / decode consumer pair.
interface ir_fetch_buffer_if #(parameter int PC_W = 32);
    logic            fetch_valid;
    logic [31:0]     fetch_data;
    logic [PC_W-1:0] fetch_pc;
    logic            fetch_ready;
    logic            decode_ready;
    logic            out_valid;
    logic [31:0]     instruction_word;
    logic [PC_W-1:0] instruction_pc;
    logic [5:0]      instruction_opcode;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [5:0]      func_code;
    logic [15:0]     alu_immediate;
    logic [31:0]     imm_sext;
    logic [31:0]     imm_zext;
    logic [25:0]     jump_target;
    logic            is_rtype;

    modport slave (
        input  fetch_valid, fetch_data, fetch_pc, decode_ready,
        output fetch_ready, out_valid, instruction_word, instruction_pc,
               instruction_opcode, rs, rt, rd, shamt, func_code,
               alu_immediate, imm_sext, imm_zext, jump_target, is_rtype
    );

    modport master (
        output fetch_valid, fetch_data, fetch_pc, decode_ready,
        input  fetch_ready, out_valid, instruction_word, instruction_pc,
               instruction_opcode, rs, rt, rd, shamt, func_code,
               alu_immediate, imm_sext, imm_zext, jump_target, is_rtype
    );
endinterface

// File: rtl/ir_fetch_buffer.sv
// DEPTH-entry instruction FIFO replacing the pass-through IR; the head entry
// is split into MIPS I fields. Empty buffer presents an all-zero NOP.
module ir_fetch_buffer #(
    parameter int DEPTH     = 2,
    parameter int PC_W      = 32,
    parameter bit BYTE_SWAP = 1'b0
) (
    input logic             clk,
    input logic             reset,
    input logic             flush,
    ir_fetch_buffer_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]     mem_w  [DEPTH];
    logic [PC_W-1:0] mem_pc [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     wdata;
    logic [31:0]     head_w;
    logic [PC_W-1:0] head_pc;
    logic            push, pop;

    // Explicit wrap so non-power-of-2 depths never index past DEPTH-1.
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    if (BYTE_SWAP) begin : g_swap
        assign wdata = {bus.fetch_data[7:0], bus.fetch_data[15:8],
                        bus.fetch_data[23:16], bus.fetch_data[31:24]};
    end else begin : g_pass
        assign wdata = bus.fetch_data;
    end

    assign bus.fetch_ready = (count != CW'(DEPTH)) && !reset;
    assign bus.out_valid   = (count != '0);
    assign push = bus.fetch_valid && bus.fetch_ready;
    assign pop  = bus.out_valid && bus.decode_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop)  rd_ptr <= nxt(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; a cleared count makes stale contents invisible.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_w[wr_ptr]  <= wdata;
            mem_pc[wr_ptr] <= bus.fetch_pc;
        end
    end

    always_comb begin
        head_w  = '0;
        head_pc = '0;
        if (count != '0) begin
            head_w  = mem_w[rd_ptr];
            head_pc = mem_pc[rd_ptr];
        end
    end

    assign bus.instruction_word   = head_w;
    assign bus.instruction_pc     = head_pc;
    assign bus.instruction_opcode = head_w[31:26];
    assign bus.rs                 = head_w[25:21];
    assign bus.rt                 = head_w[20:16];
    assign bus.rd                 = head_w[15:11];
    assign bus.shamt              = head_w[10:6];
    assign bus.func_code          = head_w[5:0];
    assign bus.alu_immediate      = head_w[15:0];
    assign bus.imm_sext           = {{16{head_w[15]}}, head_w[15:0]};
    assign bus.imm_zext           = {16'h0000, head_w[15:0]};
    assign bus.jump_target        = head_w[25:0];
    assign bus.is_rtype           = bus.out_valid && (head_w[31:26] == 6'd0);
endmodule

// File: tb/tb_ir_fetch_buffer.sv
// Four buffer variants (DEPTH 2/3/1, byte-swapped) share one stimulus stream
// and are compared every cycle against a shift-array queue model.
module tb_ir_fetch_buffer;
    logic        clk = 1'b0;
    logic        rst, fl, fv, dr;
    logic [31:0] fd, fp;
    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    ir_fetch_buffer_if #(.PC_W(32)) b2 ();
    ir_fetch_buffer_if #(.PC_W(32)) b3 ();
    ir_fetch_buffer_if #(.PC_W(32)) bs ();
    ir_fetch_buffer_if #(.PC_W(32)) b1 ();

    assign b2.fetch_valid = fv; assign b2.fetch_data = fd; assign b2.fetch_pc = fp; assign b2.decode_ready = dr;
    assign b3.fetch_valid = fv; assign b3.fetch_data = fd; assign b3.fetch_pc = fp; assign b3.decode_ready = dr;
    assign bs.fetch_valid = fv; assign bs.fetch_data = fd; assign bs.fetch_pc = fp; assign bs.decode_ready = dr;
    assign b1.fetch_valid = fv; assign b1.fetch_data = fd; assign b1.fetch_pc = fp; assign b1.decode_ready = dr;

    ir_fetch_buffer #(.DEPTH(2), .PC_W(32), .BYTE_SWAP(1'b0)) dut2 (.clk(clk), .reset(rst), .flush(fl), .bus(b2));
    ir_fetch_buffer #(.DEPTH(3), .PC_W(32), .BYTE_SWAP(1'b0)) dut3 (.clk(clk), .reset(rst), .flush(fl), .bus(b3));
    ir_fetch_buffer #(.DEPTH(2), .PC_W(32), .BYTE_SWAP(1'b1)) duts (.clk(clk), .reset(rst), .flush(fl), .bus(bs));
    ir_fetch_buffer #(.DEPTH(1), .PC_W(32), .BYTE_SWAP(1'b0)) dut1 (.clk(clk), .reset(rst), .flush(fl), .bus(b1));

    typedef struct packed {
        logic        v, rdy;
        logic [31:0] w, pc;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [31:0] se, ze;
        logic [25:0] jt;
        logic        rty;
    } obs_t;

    // Model: per variant, an array shifted down on every pop (index 0 = head).
    int          dep [4] = '{2, 3, 2, 1};
    bit          swp [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] mw  [4][16];
    logic [31:0] mp  [4][16];
    int          mn  [4] = '{0, 0, 0, 0};

    always @(posedge clk) begin
        for (int m = 0; m < 4; m++) begin
            if (rst || fl) mn[m] = 0;
            else begin
                bit po, pu;
                po = (mn[m] > 0) && dr;
                pu = fv && (mn[m] < dep[m]);
                if (po) begin
                    for (int k = 0; k < 15; k++) begin
                        mw[m][k] = mw[m][k+1];
                        mp[m][k] = mp[m][k+1];
                    end
                    mn[m]--;
                end
                if (pu) begin
                    mw[m][mn[m]] = swp[m] ? {fd[7:0], fd[15:8], fd[23:16], fd[31:24]} : fd;
                    mp[m][mn[m]] = fp;
                    mn[m]++;
                end
            end
        end
    end

    function automatic obs_t expect_of(int m);
        obs_t o;
        logic [31:0] w;
        o = '0;
        o.rdy = (mn[m] < dep[m]) && !rst;
        if (mn[m] > 0) begin
            w    = mw[m][0];
            o.v  = 1'b1;
            o.w  = w;
            o.pc = mp[m][0];
            o.op = 6'(w >> 26);
            o.rs = 5'((w >> 21) & 32'h1F);
            o.rt = 5'((w >> 16) & 32'h1F);
            o.rd = 5'((w >> 11) & 32'h1F);
            o.sh = 5'((w >> 6) & 32'h1F);
            o.fn = 6'(w & 32'h3F);
            o.imm = 16'(w & 32'hFFFF);
            o.se = (w & 32'h8000) != 0 ? (w | 32'hFFFF0000) : (w & 32'hFFFF);
            o.ze = w & 32'hFFFF;
            o.jt = 26'(w & 32'h03FF_FFFF);
            o.rty = (o.op == 6'd0);
        end
        return o;
    endfunction

    obs_t act [4];
    always_comb begin
        act[0] = '{b2.out_valid, b2.fetch_ready, b2.instruction_word, b2.instruction_pc, b2.instruction_opcode,
                   b2.rs, b2.rt, b2.rd, b2.shamt, b2.func_code, b2.alu_immediate, b2.imm_sext, b2.imm_zext,
                   b2.jump_target, b2.is_rtype};
        act[1] = '{b3.out_valid, b3.fetch_ready, b3.instruction_word, b3.instruction_pc, b3.instruction_opcode,
                   b3.rs, b3.rt, b3.rd, b3.shamt, b3.func_code, b3.alu_immediate, b3.imm_sext, b3.imm_zext,
                   b3.jump_target, b3.is_rtype};
        act[2] = '{bs.out_valid, bs.fetch_ready, bs.instruction_word, bs.instruction_pc, bs.instruction_opcode,
                   bs.rs, bs.rt, bs.rd, bs.shamt, bs.func_code, bs.alu_immediate, bs.imm_sext, bs.imm_zext,
                   bs.jump_target, bs.is_rtype};
        act[3] = '{b1.out_valid, b1.fetch_ready, b1.instruction_word, b1.instruction_pc, b1.instruction_opcode,
                   b1.rs, b1.rt, b1.rd, b1.shamt, b1.func_code, b1.alu_immediate, b1.imm_sext, b1.imm_zext,
                   b1.jump_target, b1.is_rtype};
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int m = 0; m < 4; m++) begin
                obs_t e;
                e = expect_of(m);
                checks++;
                if (act[m] !== e) begin
                    errors++;
                    $display("FAIL model dut%0d t=%0t act=%h exp=%h", m, $time, act[m], e);
                end
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s t=%0t act=%h exp=%h", nm, $time, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; fl = 1'b0; fv = 1'b1; dr = 1'b0; fd = 32'hDEADBEEF; fp = 32'h100;
        tick();
        chk_en = 1'b1;
        at_neg();
        lit("rst_valid", 32'(b2.out_valid), 0);
        lit("rst_word", b2.instruction_word, 0);
        tick(); tick();
        rst = 1'b0; fv = 1'b0;
        at_neg();
        lit("post_rst_valid", 32'(b2.out_valid), 0);
        lit("post_rst_ready", 32'(b2.fetch_ready), 1);
        lit("post_rst_word", b2.instruction_word, 0);
        tick();

        // R-type add $8,$9,$10
        fv = 1'b1; fd = 32'h012A4020; fp = 32'h400; dr = 1'b1;
        tick();
        fv = 1'b0;
        at_neg();
        lit("r_valid", 32'(b2.out_valid), 1);
        lit("r_op", 32'(b2.instruction_opcode), 0);
        lit("r_rs", 32'(b2.rs), 9);
        lit("r_rt", 32'(b2.rt), 10);
        lit("r_rd", 32'(b2.rd), 8);
        lit("r_shamt", 32'(b2.shamt), 0);
        lit("r_func", 32'(b2.func_code), 32'h20);
        lit("r_rtype", 32'(b2.is_rtype), 1);
        lit("r_pc", b2.instruction_pc, 32'h400);
        tick();
        at_neg();
        lit("r_popped", 32'(b2.out_valid), 0);

        // addi with negative immediate, held through a 5-cycle stall
        dr = 1'b0; fv = 1'b1; fd = 32'h2108FFFC; fp = 32'h404;
        tick();
        fv = 1'b0;
        for (int i = 0; i < 5; i++) begin
            at_neg();
            lit("stall_imm", 32'(b2.alu_immediate), 32'hFFFC);
            lit("stall_sext", b2.imm_sext, 32'hFFFFFFFC);
            lit("stall_zext", b2.imm_zext, 32'h0000FFFC);
            lit("stall_word", b2.instruction_word, 32'h2108FFFC);
            tick();
        end
        dr = 1'b1;
        tick();
        dr = 1'b0;

        // Fill DEPTH=3 and offer a fourth word
        fv = 1'b1;
        fd = 32'hA; fp = 32'h10; tick();
        fd = 32'hB; fp = 32'h14; tick();
        fd = 32'hC; fp = 32'h18; tick();
        fd = 32'hD; fp = 32'h1C;
        at_neg();
        lit("d3_full_ready", 32'(b3.fetch_ready), 0);
        lit("d1_full_ready", 32'(b1.fetch_ready), 0);
        tick();
        fv = 1'b0; dr = 1'b1;
        at_neg(); lit("d3_pop_a", b3.instruction_word, 32'hA); tick();
        at_neg(); lit("d3_pop_b", b3.instruction_word, 32'hB); tick();
        at_neg(); lit("d3_pop_c", b3.instruction_word, 32'hC); tick();
        at_neg(); lit("d3_empty", 32'(b3.out_valid), 0);

        // Refill streaming push+pop so pointers lap the ring
        fv = 1'b1;
        for (int i = 0; i < 7; i++) begin
            fd = 32'h100 + 32'(i); fp = 32'h40 + 32'(4 * i);
            tick();
        end
        fv = 1'b0;
        at_neg();
        lit("d3_wrap_head", b3.instruction_word, 32'h106);
        lit("d1_wrap_head", b1.instruction_word, 32'h106);
        tick();
        dr = 1'b0;

        // Flush with two buffered words and a concurrent push
        fv = 1'b1;
        fd = 32'h11; tick();
        fd = 32'h22; tick();
        fl = 1'b1; fd = 32'h33;
        at_neg();
        lit("flush_ready_pre", 32'(b2.fetch_ready), 0);
        tick();
        fl = 1'b0; fv = 1'b0;
        at_neg();
        lit("flush_valid2", 32'(b2.out_valid), 0);
        lit("flush_valid3", 32'(b3.out_valid), 0);
        tick();
        at_neg();
        lit("flush_absent", 32'(b3.out_valid), 0);

        // Byte-swapped variant
        fv = 1'b1; fd = 32'h20404000; fp = 32'h500;
        tick();
        fv = 1'b0;
        at_neg();
        lit("bs_word", bs.instruction_word, 32'h00404020);
        lit("bs_rd", 32'(bs.rd), 8);
        lit("bs_func", 32'(bs.func_code), 32'h20);
        lit("nobs_word", b2.instruction_word, 32'h20404000);

        // Reset mid-stall drops everything
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        at_neg();
        lit("rst_stall_valid", 32'(b2.out_valid), 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
